// File: rtl/counter_cmd_sequencer_if.sv
// Command handshake bundle for counter_cmd_sequencer.
// master offers commands, slave accepts them with cmd_ready.
interface counter_cmd_sequencer_if #(
  parameter int N     = 16,
  parameter int RPT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [N-1:0]     cmd_data;
  logic [RPT_W-1:0] cmd_rpt;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_rpt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_rpt,
    output cmd_ready
  );
endinterface

// File: rtl/counter_cmd_sequencer.sv
// Buffers timed counter commands in a FIFO and replays them gaplessly.
// Optional CMD_SEQ_LOOP_EN adds loop_en to recirculate retired commands.
module counter_cmd_sequencer #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int RPT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
`ifdef CMD_SEQ_LOOP_EN
  input  logic                     loop_en,
`endif
  counter_cmd_sequencer_if.slave   cmd,
  output logic [1:0]               control,
  output logic [N-1:0]             parallel_in,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = 2 + N + RPT_W;
  localparam logic [RPT_W-1:0] ONE_R = 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [W-1:0]     mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [RPT_W-1:0] rpt_cnt, rpt_d;
  logic [1:0]       ctl_d;
  logic [N-1:0]     dat_d;
  logic             busy_d;

  logic             empty, full, last, pop, drain;
  logic             push, wr;
  logic [W-1:0]     wr_data, head;
  logic [1:0]       head_op;
  logic [N-1:0]     head_data;
  logic [RPT_W-1:0] head_rpt;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign last  = (state_q == RUN) && (rpt_cnt == '0);
  assign pop   = !flush && !empty && ((state_q == IDLE) || last);
  assign drain = !flush && last && empty;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_op   = head[W-1 -: 2];
  assign head_data = head[RPT_W +: N];
  assign head_rpt  = head[RPT_W-1:0];

`ifdef CMD_SEQ_LOOP_EN
  logic [RPT_W-1:0] cur_rpt;
  logic             loop_wr;

  // The retiring command goes back on the tail in the cycle it pops.
  assign loop_wr = loop_en && last && !flush;
  assign cmd.cmd_ready = !full && !flush && !loop_en;
  assign push    = cmd.cmd_valid && cmd.cmd_ready;
  assign wr      = push || loop_wr;
  assign wr_data = push ? {cmd.cmd_op, cmd.cmd_data, cmd.cmd_rpt}
                        : {control, parallel_in, cur_rpt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cur_rpt <= '0;
    else if (pop)   cur_rpt <= head_rpt;
  end
`else
  assign cmd.cmd_ready = !full && !flush;
  assign push    = cmd.cmd_valid && cmd.cmd_ready;
  assign wr      = push;
  assign wr_data = {cmd.cmd_op, cmd.cmd_data, cmd.cmd_rpt};
`endif

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, wr};
      rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
    end
  end

  assign fifo_level = wr_ptr - rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      flush:   state_d = IDLE;
      pop:     state_d = RUN;
      drain:   state_d = IDLE;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    ctl_d  = control;
    dat_d  = parallel_in;
    busy_d = busy;
    rpt_d  = rpt_cnt;
    unique case (1'b1)
      flush || drain: begin
        ctl_d  = 2'b00;
        dat_d  = '0;
        busy_d = 1'b0;
        rpt_d  = '0;
      end
      pop: begin
        ctl_d  = head_op;
        dat_d  = head_data;
        busy_d = 1'b1;
        rpt_d  = head_rpt;
      end
      (state_q == RUN) && !last && !flush: begin
        rpt_d = rpt_cnt - ONE_R;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      control     <= 2'b00;
      parallel_in <= '0;
      busy        <= 1'b0;
      rpt_cnt     <= '0;
    end else begin
      control     <= ctl_d;
      parallel_in <= dat_d;
      busy        <= busy_d;
      rpt_cnt     <= rpt_d;
    end
  end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Randomized and directed bench for counter_cmd_sequencer.
// A queue-based command model predicts outputs each cycle.
module tb_counter_cmd_sequencer;

  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int RPT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       control;
  logic [N-1:0]     parallel_in;
  logic             busy;
  logic [$clog2(DEPTH):0] fifo_level;

  counter_cmd_sequencer_if #(.N(N), .RPT_W(RPT_W)) cmd ();

  counter_cmd_sequencer #(
    .N(N), .DEPTH(DEPTH), .RPT_W(RPT_W)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
`ifdef CMD_SEQ_LOOP_EN
    .loop_en     (1'b0),
`endif
    .cmd         (cmd),
    .control     (control),
    .parallel_in (parallel_in),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] data;
    int           rpt;
  } cmd_t;

  cmd_t q[$];
  cmd_t cur;
  bit   cur_v;
  int   remain;
  int   vecs;
  int   errs;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outs();
    chk("control", 32'(control), cur_v ? 32'(cur.op) : 32'd0);
    chk("parallel_in", 32'(parallel_in), cur_v ? 32'(cur.data) : 32'd0);
    chk("busy", 32'(busy), 32'(cur_v));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
  endtask

  // One clock: drive inputs, check ready, advance model, check outputs.
  task automatic step(input bit f, input bit v, input logic [1:0] op,
                      input logic [N-1:0] d, input int r, output bit acc);
    cmd_t c;
    logic [31:0] rv;
    rv = r;
    flush         = f;
    cmd.cmd_valid = v;
    cmd.cmd_op    = op;
    cmd.cmd_data  = d;
    cmd.cmd_rpt   = rv[RPT_W-1:0];
    #1;
    chk("cmd_ready", 32'(cmd.cmd_ready), 32'(!f && q.size() < DEPTH));
    acc = v && !f && (q.size() < DEPTH);
    @(posedge clk);
    if (f) begin
      q.delete();
      cur_v = 1'b0;
    end else begin
      if (!cur_v || remain == 1) begin
        if (q.size() > 0) begin
          cur    = q.pop_front();
          remain = cur.rpt + 1;
          cur_v  = 1'b1;
        end else begin
          cur_v = 1'b0;
        end
      end else begin
        remain--;
      end
      if (acc) begin
        c.op   = op;
        c.data = d;
        c.rpt  = r;
        q.push_back(c);
      end
    end
    #1;
    chk_outs();
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, '0, 0, a);
  endtask

  task automatic offer(input logic [1:0] op, input logic [N-1:0] d,
                       input int r);
    bit a;
    int tries;
    tries = 0;
    do begin
      step(1'b0, 1'b1, op, d, r, a);
      tries++;
    end while (!a && tries < 600);
    if (!a) chk("offer_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    q.delete();
    cur_v = 1'b0;
    chk_outs();
    @(posedge clk);
    #2;
    chk_outs();
    rst_n = 1'b1;
  endtask

  initial begin
    bit a;
    vecs  = 0;
    errs  = 0;
    cur_v = 1'b0;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = 2'b00;
    cmd.cmd_data  = '0;
    cmd.cmd_rpt   = '0;
    repeat (2) @(posedge clk);
    #2;
    chk_outs();
    rst_n = 1'b1;
    idle(2);

    step(1'b0, 1'b1, 2'b01, 16'h1234, 3, a);
    idle(6);

    step(1'b0, 1'b1, 2'b11, 16'h00F0, 0, a);
    step(1'b0, 1'b1, 2'b10, 16'h0000, 1, a);
    idle(4);

    for (int i = 0; i < 5; i++)
      offer(2'(i), 16'(16'hA000 + i), 7);
    idle(45);

    for (int i = 0; i < 4; i++)
      offer(2'b01, 16'(i), 7);
    step(1'b1, 1'b1, 2'b11, 16'hBEEF, 2, a);
    idle(3);

    offer(2'b10, 16'h5555, 20);
    idle(4);
    do_reset();
    idle(2);

    offer(2'b01, 16'h0F0F, 255);
    offer(2'b11, 16'h7777, 0);
    idle(262);

    for (int i = 0; i < 600; i++) begin
      step(($urandom % 40) == 0,
           ($urandom % 3) != 0,
           2'($urandom),
           16'($urandom),
           (($urandom % 8) == 0) ? int'($urandom_range(4, 20))
                                 : int'($urandom_range(0, 3)),
           a);
    end
    idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
